// File: rtl/hier_fanout_node.sv
// Command fan-out node: routes each parent command to one child slot, or broadcasts it to all slots.
// Also provides illegal-destination accounting, a command counter and a drain/flush handshake.
module hier_fanout_node #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_bcast,
  input  logic [IDX_W-1:0]               in_dest,
  input  logic [DATA_W-1:0]              in_data,
  output logic [NUM_CHILDREN-1:0]        out_valid,
  input  logic [NUM_CHILDREN-1:0]        out_ready,
  output logic [NUM_CHILDREN*DATA_W-1:0] out_data,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           err_pulse,
  output logic [7:0]                     err_count,
  output logic [15:0]                    cmd_count
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

  state_t                  state, state_next;
  logic [NUM_CHILDREN-1:0] slot_free;
  logic [NUM_CHILDREN-1:0] dest_hit;
  logic [NUM_CHILDREN-1:0] load;
  logic                    dest_legal;
  logic                    room;
  logic                    accept;
  logic                    illegal_acc;
  logic                    legal_acc;

  // A slot can take a new command when it is empty or being drained this same cycle.
  assign slot_free = ~out_valid | out_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dest_hit = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      dest_hit[i] = (in_dest == IDX_W'(i));
    end
  end

  assign dest_legal = |dest_hit;

  always_comb begin
    room = 1'b1;
    if (in_bcast)        room = &slot_free;
    else if (dest_legal) room = |(dest_hit & slot_free);
  end

  // Illegal destinations are always consumed, so room stays high for them.
  assign in_ready    = !rst && (state == RUN) && !flush_req && room;
  assign accept      = in_valid && in_ready;
  assign illegal_acc = accept && !in_bcast && !dest_legal;
  assign legal_acc   = accept && !illegal_acc;
  assign load        = {NUM_CHILDREN{legal_acc}} & (in_bcast ? {NUM_CHILDREN{1'b1}} : dest_hit);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the payload registers are reset too, so out_data reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        if (load[i]) begin
          out_valid[i]                   <= 1'b1;
          out_data[i*DATA_W +: DATA_W]   <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]                   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      cmd_count <= '0;
    end else begin
      err_pulse <= illegal_acc;
      if (illegal_acc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (legal_acc)                            cmd_count <= cmd_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:   if (flush_req)   state_next = DRAIN;
      DRAIN: if (~|out_valid) state_next = DONE;
      DONE:  state_next = flush_req ? HOLD : RUN;
      HOLD:  if (!flush_req)  state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign flush_done = (state == DONE);

endmodule

// File: tb/tb_hier_fanout_node.sv
// Directed bench for hier_fanout_node (5 children, 16-bit payload): each task drives one scenario
// and compares outputs against hand-computed values.
module tb_hier_fanout_node;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_bcast;
  logic [IW-1:0]  in_dest;
  logic [W-1:0]   in_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*W-1:0] out_data;
  logic           flush_req;
  logic           flush_done;
  logic           err_pulse;
  logic [7:0]     err_count;
  logic [15:0]    cmd_count;

  int n_vec = 0;
  int n_bad = 0;

  hier_fanout_node #(.NUM_CHILDREN(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcast(in_bcast),
    .in_dest(in_dest), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .err_pulse(err_pulse), .err_count(err_count), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic bc, input logic [IW-1:0] d, input logic [W-1:0] v);
    in_valid = 1'b1; in_bcast = bc; in_dest = d; in_data = v;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_bcast = 1'b0; in_dest = '0; in_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); out_ready = '1; flush_req = 1'b0;
    in_valid = 1'b1;
    repeat (2) step();
    n_vec++; if (out_valid !== 5'b0)  begin n_bad++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 5'b0); end
    n_vec++; if (out_data !== '0)     begin n_bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    n_vec++; if (cmd_count !== 16'd0) begin n_bad++; $display("FAIL reset_cmd got=%0d exp=0", cmd_count); end
    n_vec++; if (err_count !== 8'd0)  begin n_bad++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    n_vec++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (flush_done !== 1'b0 || err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got=%b%b exp=00", flush_done, err_pulse); end
    idle();
    rst = 1'b0;
    step();
  endtask

  task automatic test_unicast();
    out_ready = '1;
    send(1'b0, 3'd3, 16'hA5A5);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL uni_ready got=%b exp=1", in_ready); end
    step(); idle();
    n_vec++; if (out_valid !== 5'b01000) begin n_bad++; $display("FAIL uni_valid got=%b exp=01000", out_valid); end
    n_vec++; if (out_data[3*W +: W] !== 16'hA5A5) begin n_bad++; $display("FAIL uni_data got=%h exp=a5a5", out_data[3*W +: W]); end
    n_vec++; if (cmd_count !== 16'd1) begin n_bad++; $display("FAIL uni_cmd got=%0d exp=1", cmd_count); end
    step();
    n_vec++; if (out_valid !== 5'b0) begin n_bad++; $display("FAIL uni_drain got=%b exp=00000", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 5'b11011;
    send(1'b0, 3'd2, 16'h1111);
    step();
    send(1'b0, 3'd2, 16'h2222);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_block got=%b exp=0", in_ready); end
    step();
    n_vec++; if (out_valid !== 5'b00100 || out_data[2*W +: W] !== 16'h1111) begin n_bad++; $display("FAIL bp_hold got=%b/%h exp=00100/1111", out_valid, out_data[2*W +: W]); end
    out_ready = 5'b11111;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    step(); idle();
    n_vec++; if (out_valid !== 5'b00100 || out_data[2*W +: W] !== 16'h2222) begin n_bad++; $display("FAIL bp_second got=%b/%h exp=00100/2222", out_valid, out_data[2*W +: W]); end
    n_vec++; if (cmd_count !== 16'd3) begin n_bad++; $display("FAIL bp_cmd got=%0d exp=3", cmd_count); end
    step();
  endtask

  task automatic test_broadcast();
    out_ready = 5'b11101;
    send(1'b0, 3'd1, 16'h0B0B);
    step();
    send(1'b1, 3'd6, 16'h1234);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bc_gate0 got=%b exp=0", in_ready); end
    step();
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 5'b00010) begin n_bad++; $display("FAIL bc_gate1 got=%b/%b exp=0/00010", in_ready, out_valid); end
    out_ready = 5'b11111;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bc_open got=%b exp=1", in_ready); end
    step(); idle();
    n_vec++; if (out_valid !== 5'b11111) begin n_bad++; $display("FAIL bc_valid got=%b exp=11111", out_valid); end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (out_data[i*W +: W] !== 16'h1234) begin n_bad++; $display("FAIL bc_data%0d got=%h exp=1234", i, out_data[i*W +: W]); end
    end
    n_vec++; if (cmd_count !== 16'd5) begin n_bad++; $display("FAIL bc_cmd got=%0d exp=5", cmd_count); end
    step();
  endtask

  task automatic test_illegal();
    out_ready = '1;
    send(1'b0, 3'd6, 16'hDEAD);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    step();
    send(1'b0, 3'd7, 16'hBEEF);
    n_vec++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin n_bad++; $display("FAIL ill_first got=%b/%0d exp=1/1", err_pulse, err_count); end
    step(); idle();
    n_vec++; if (err_pulse !== 1'b1 || err_count !== 8'd2) begin n_bad++; $display("FAIL ill_second got=%b/%0d exp=1/2", err_pulse, err_count); end
    n_vec++; if (out_valid !== 5'b0 || cmd_count !== 16'd5) begin n_bad++; $display("FAIL ill_noload got=%b/%0d exp=00000/5", out_valid, cmd_count); end
    step();
    n_vec++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL ill_pulse_end got=%b exp=0", err_pulse); end
    send(1'b0, 3'd7, 16'h0000);
    repeat (300) step();
    idle();
    n_vec++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL ill_sat got=%0d exp=255", err_count); end
    n_vec++; if (cmd_count !== 16'd5) begin n_bad++; $display("FAIL ill_cmd got=%0d exp=5", cmd_count); end
    step();
  endtask

  task automatic test_flush();
    out_ready = '0;
    send(1'b0, 3'd0, 16'h00A0); step();
    send(1'b0, 3'd1, 16'h00A1); step();
    send(1'b0, 3'd2, 16'h00A2); step();
    flush_req = 1'b1;
    send(1'b0, 3'd4, 16'h00A4);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_first_seen got=%b exp=0", in_ready); end
    step();
    n_vec++; if (in_ready !== 1'b0 || flush_done !== 1'b0) begin n_bad++; $display("FAIL fl_drain got=%b/%b exp=0/0", in_ready, flush_done); end
    step(); idle();
    n_vec++; if (out_valid !== 5'b00111 || flush_done !== 1'b0) begin n_bad++; $display("FAIL fl_held got=%b/%b exp=00111/0", out_valid, flush_done); end
    out_ready = '1;
    step();
    n_vec++; if (out_valid !== 5'b0 || flush_done !== 1'b0) begin n_bad++; $display("FAIL fl_emptied got=%b/%b exp=00000/0", out_valid, flush_done); end
    step();
    n_vec++; if (flush_done !== 1'b1) begin n_bad++; $display("FAIL fl_done got=%b exp=1", flush_done); end
    step();
    n_vec++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL fl_done_once got=%b exp=0", flush_done); end
    send(1'b0, 3'd4, 16'h00A4);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_hold got=%b exp=0", in_ready); end
    flush_req = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_hold_exit got=%b exp=0", in_ready); end
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_run got=%b exp=1", in_ready); end
    step(); idle();
    n_vec++; if (out_valid !== 5'b10000 || cmd_count !== 16'd9) begin n_bad++; $display("FAIL fl_accept got=%b/%0d exp=10000/9", out_valid, cmd_count); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = '0;
    send(1'b0, 3'd0, 16'h0C00); step();
    send(1'b0, 3'd1, 16'h0C01); step();
    idle();
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 5'b0) begin n_bad++; $display("FAIL rm_valid got=%b exp=00000", out_valid); end
    n_vec++; if (cmd_count !== 16'd0 || err_count !== 8'd0) begin n_bad++; $display("FAIL rm_counts got=%0d/%0d exp=0/0", cmd_count, err_count); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    out_ready = '1;
    send(1'b0, 3'd0, 16'h5555);
    repeat (65535) step();
    n_vec++; if (cmd_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_max got=%0d exp=65535", cmd_count); end
    step(); idle();
    n_vec++; if (cmd_count !== 16'd0) begin n_bad++; $display("FAIL wrap_zero got=%0d exp=0", cmd_count); end
    step();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hier_fanout_node.md
# hier_fanout_node

Parametrised command fan-out node for the generated module hierarchy. It accepts one command stream from its parent and routes each command to one of NUM_CHILDREN child ports, or broadcasts it to all of them. Each child port has a one-entry output register with a valid/ready handshake. The node also provides drop/error accounting and a flush sequence that drains the node before a hierarchy reconfiguration. It sits at every interior node of the tree and replaces the fixed five-child, portless wrapper node.

## Interface
- NUM_CHILDREN, 5, number of child ports; legal range 1..16
- DATA_W, 16, command payload width
- IDX_W, derived: $clog2(NUM_CHILDREN), minimum 1; destination index width
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  parent command valid
- in_ready  output  1  node accepts command this cycle
- in_bcast  input  1  1 = broadcast to all children; in_dest ignored
- in_dest  input  IDX_W  unicast destination index
- in_data  input  DATA_W  payload
- out_valid  output  NUM_CHILDREN  per-child valid
- out_ready  input  NUM_CHILDREN  per-child ready
- out_data  output  NUM_CHILDREN*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W]
- flush_req  input  1  level; request drain
- flush_done  output  1  one-cycle pulse when drain completes
- err_pulse  output  1  one-cycle pulse on an illegal destination
- err_count  output  8  saturating count of illegal destinations
- cmd_count  output  16  wrapping count of accepted commands

## Operation
- Per-child slot i:
  - Slot i is free when out_valid[i]=0, or when out_valid[i]=1 and out_ready[i]=1 in the same cycle (drain and refill in one cycle).
  - Data is stable while out_valid[i]=1 and out_ready[i]=0.
- Unicast, in_dest < NUM_CHILDREN: in_ready = slot[in_dest] free.
- Broadcast: in_ready = all slots free. On acceptance every slot loads in_data.
- Illegal destination (in_dest >= NUM_CHILDREN, in_bcast=0):
  - in_ready=1 and the command is consumed.
  - No slot loads.
  - err_pulse=1 the following cycle.
  - err_count increments, saturating at 255.
- cmd_count increments by 1 for each accepted legal command. A broadcast counts once. The counter wraps from 65535 to 0. Illegal commands are not counted.
- in_ready is combinational from slot state, state and in_* fields. in_ready is 0 whenever state != RUN.
- State machine:
  - RUN: normal operation. flush_req=1 goes to DRAIN. No command is accepted in the cycle where flush_req is first seen.
  - DRAIN: in_ready=0. Slots continue to drain. When all out_valid=0, go to DONE.
  - DONE: flush_done=1 for exactly one cycle. Next state is RUN if flush_req=0, otherwise HOLD.
  - HOLD: in_ready=0. Return to RUN when flush_req=0.
- If all slots are already empty when flush_req rises: RUN, then DRAIN for one cycle, then DONE.
- Reset (asynchronous, any state): state=RUN. All out_valid=0, out_data=0, err_count=0, cmd_count=0, flush_done=0, err_pulse=0. in_ready=0 while rst=1. Any command in flight mid-transfer is discarded.

## Timing
- Latency: command accepted at edge t gives out_valid at cycle t+1.
- Throughput: one command per cycle, per child, with out_ready held high. Back-to-back commands to different children also run at one per cycle.
- err_pulse, err_count and cmd_count update at the edge of acceptance. They are visible in the next cycle.
- flush_done is asserted one cycle after the cycle in which the last out_valid deasserts.
- No combinational path from out_ready to out_valid. There is a path from out_ready to in_ready (slot-free term).

## Test plan
- **Reset and unicast:** NUM_CHILDREN=5. Reset, then send in_dest=3, in_data=0xA5A5 with all out_ready=1. Required: out_valid=5'b01000 for one cycle, out_data[3]=0xA5A5, cmd_count=1.
- **Backpressure:** out_ready[2]=0. Send two commands to dest 2. Required: first is held stable and in_ready=0 for the second. Raise out_ready[2]; the second is accepted in the same cycle the first drains, with no bubble.
- **Broadcast gating:** slot 1 is full with out_ready[1]=0. Send a broadcast 0x1234. Required: in_ready=0 until slot 1 drains. Then all 5 out_valid are high with 0x1234, and cmd_count increments by 1.
- **Illegal destination:** send in_dest=6 and in_dest=7 (IDX_W=3). Required: both are consumed, 2 err_pulses, err_count=2, no out_valid, cmd_count unchanged. Send 300 illegal commands: err_count=255.
- **Flush:** 3 slots full, out_ready=0. Assert flush_req. Required: in_ready=0. Release out_ready; flush_done pulses once, one cycle after the last slot empties. The node stays in HOLD until flush_req=0, then accepts again.
- **Reset mid-operation and wrap:** assert rst asynchronously with slots full. Required: out_valid=0 immediately, counters=0. Separately, 65536 accepted commands return cmd_count to 0.
